// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master round-robin arbiter in front of one valid/ready
// memory slave. One transaction in flight, plus a watchdog for a silent slave.

// Per-master response path: completion, timeout flag and read-data substitution.
module mem_bus_arbiter_port #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA  = '0
) (
    input  logic                  sel,
    input  logic                  done,
    input  logic                  tmo,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    output logic                  ready,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata
);

    assign ready = sel & done;
    assign err   = sel & tmo;
    assign rdata = (sel && tmo) ? ERR_RDATA : s_rdata;

endmodule

module mem_bus_arbiter #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    m0_valid,
    output logic                    m0_ready,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_wen,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    output logic                    m0_err,

    input  logic                    m1_valid,
    output logic                    m1_ready,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_wen,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic                    m1_err,

    output logic                    s_valid,
    input  logic                    s_ready,
    output logic [ADDR_WIDTH-1:0]   s_addr,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    output logic [DATA_WIDTH/8-1:0] s_wen,
    input  logic [DATA_WIDTH-1:0]   s_rdata,

    output logic [1:0]              grant
);

    localparam int WEN_W = DATA_WIDTH / 8;
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_M0 = 2'd1,
        BUSY_M1 = 2'd2,
        RELEASE = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [WEN_W-1:0]      wen;
    } req_t;

    state_t           state, state_nxt;
    logic             last_grant, last_grant_nxt;  // 0 = m0 won last, 1 = m1
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic [1:0]       m_valid;
    req_t [1:0]       m_req;
    logic             own;
    logic             done;
    logic             tmo;

    logic [1:0]                 m_ready;
    logic [1:0]                 m_err;
    logic [1:0][DATA_WIDTH-1:0] m_rdata;

    assign m_valid  = {m1_valid, m0_valid};
    assign m_req[0] = '{addr: m0_addr, wdata: m0_wdata, wen: m0_wen};
    assign m_req[1] = '{addr: m1_addr, wdata: m1_wdata, wen: m1_wen};

    assign own   = (state == BUSY_M1);
    assign grant = {state == BUSY_M1, state == BUSY_M0};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            cnt        <= cnt_nxt;
        end
    end

    // Abort beats completion beats timeout: a dropped request never gets a ready.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        cnt_nxt        = cnt;
        done           = 1'b0;
        tmo            = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (m_valid[0] && (!m_valid[1] || last_grant))
                    state_nxt = BUSY_M0;
                else if (m_valid[1])
                    state_nxt = BUSY_M1;
            end
            BUSY_M0, BUSY_M1: begin
                if (!m_valid[own]) begin
                    state_nxt = RELEASE;
                end else if (s_ready) begin
                    done           = 1'b1;
                    last_grant_nxt = own;
                    state_nxt      = RELEASE;
                end else if (cnt == TMO_LIM) begin
                    done           = 1'b1;
                    tmo            = 1'b1;
                    last_grant_nxt = own;
                    state_nxt      = RELEASE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign s_valid = (grant != 2'b00) && m_valid[own] && !tmo;
    assign s_addr  = m_req[own].addr;
    assign s_wdata = m_req[own].wdata;
    assign s_wen   = m_req[own].wen;

    for (genvar i = 0; i < 2; i++) begin : g_port
        mem_bus_arbiter_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .ERR_RDATA  (ERR_RDATA)
        ) u_port (
            .sel     (grant[i]),
            .done    (done),
            .tmo     (tmo),
            .s_rdata (s_rdata),
            .ready   (m_ready[i]),
            .err     (m_err[i]),
            .rdata   (m_rdata[i])
        );
    end

    assign m0_ready = m_ready[0];
    assign m1_ready = m_ready[1];
    assign m0_err   = m_err[0];
    assign m1_err   = m_err[1];
    assign m0_rdata = m_rdata[0];
    assign m1_rdata = m_rdata[1];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus a randomized run checked
// against a cycle-timeline model of the arbitration rules.
module tb_mem_bus_arbiter;

    localparam int T = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m0_ready, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wen;
    logic        m1_valid, m1_ready, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wen;
    logic        s_valid, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wen;
    logic [1:0]  grant;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T), .ERR_RDATA(ERR)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wen(m0_wen), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wen(m1_wen), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wen(s_wen), .s_rdata(s_rdata), .grant(grant)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wen = 0;
        m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wen = 0;
        s_ready = 0; s_rdata = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        idle_inputs();
        repeat (2) step();
        reset = 0;
        step();
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        m0_valid = 1; s_ready = 1;
        step(); step();
        settle();
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b want=00", grant); end
        total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL reset_s_valid got=%b want=0", s_valid); end
        total++; if ({m1_ready, m0_ready, m1_err, m0_err} !== 4'b0) begin
            bad++; $display("FAIL reset_ready_err got=%b want=0000", {m1_ready, m0_ready, m1_err, m0_err});
        end
        step(); reset = 0; m0_valid = 0; s_ready = 0;
        step(); m0_valid = 1; m1_valid = 1;
        step(); s_ready = 1;
        settle();
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL reset_first_win got=%b want=01", grant); end
        step(); idle_inputs();
        settle();
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_release got=%b want=00", grant); end
        step();
    endtask

    task automatic test_single_read();
        step(); m0_valid = 1; m0_addr = 32'h20400000; m0_wen = 4'b0000;
        settle();
        total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL rd_c0_s_valid got=%b want=0", s_valid); end
        step(); settle();
        total++; if ({s_valid, grant} !== 3'b101) begin bad++; $display("FAIL rd_c1_valid_grant got=%b want=101", {s_valid, grant}); end
        total++; if (s_addr !== 32'h20400000) begin bad++; $display("FAIL rd_c1_addr got=%h want=20400000", s_addr); end
        step(); s_ready = 1; s_rdata = 32'h00000013;
        settle();
        total++; if ({m0_ready, m0_err, m1_ready} !== 3'b100) begin
            bad++; $display("FAIL rd_c2_ready got=%b want=100", {m0_ready, m0_err, m1_ready});
        end
        total++; if (m0_rdata !== 32'h00000013) begin bad++; $display("FAIL rd_c2_rdata got=%h want=00000013", m0_rdata); end
        step(); m0_valid = 0; s_ready = 0;
        settle();
        total++; if ({s_valid, grant} !== 3'b000) begin bad++; $display("FAIL rd_c3_release got=%b want=000", {s_valid, grant}); end
        step();
    endtask

    task automatic test_contention();
        bit last_w, exp_w;
        logic [1:0] oh;
        do_reset();
        m0_valid = 1; m1_valid = 1; s_ready = 1;
        last_w = 1;
        for (int i = 0; i < 4; i++) begin
            exp_w = !last_w;
            oh = exp_w ? 2'b10 : 2'b01;
            step(); settle();
            total++; if (grant !== oh) begin bad++; $display("FAIL cont_grant%0d got=%b want=%b", i, grant, oh); end
            total++; if ({m1_ready, m0_ready} !== oh) begin
                bad++; $display("FAIL cont_ready%0d got=%b want=%b", i, {m1_ready, m0_ready}, oh);
            end
            last_w = exp_w;
            step(); settle();
            total++; if ({s_valid, grant, m1_ready, m0_ready} !== 5'b0) begin
                bad++; $display("FAIL cont_release%0d got=%b want=00000", i, {s_valid, grant, m1_ready, m0_ready});
            end
            step();
            if (i == 3) begin m0_valid = 0; m1_valid = 0; s_ready = 0; end
        end
    endtask

    task automatic test_write_mux();
        step();
        m0_addr = 32'h11111111; m0_wdata = 32'h22222222; m0_wen = 4'b1111;
        m1_valid = 1; m1_addr = 32'h20400010; m1_wdata = 32'hCAFEBABE; m1_wen = 4'b0011;
        for (int k = 0; k < 2; k++) begin
            step(); settle();
            total++; if ({s_addr, s_wdata, s_wen} !== {32'h20400010, 32'hCAFEBABE, 4'b0011}) begin
                bad++; $display("FAIL wr_mux%0d got=%h/%h/%b want=20400010/cafebabe/0011", k, s_addr, s_wdata, s_wen);
            end
            total++; if ({grant, m0_ready} !== 3'b100) begin bad++; $display("FAIL wr_grant%0d got=%b want=100", k, {grant, m0_ready}); end
        end
        step(); s_ready = 1;
        settle();
        total++; if ({m1_ready, m0_ready} !== 2'b10) begin bad++; $display("FAIL wr_done got=%b want=10", {m1_ready, m0_ready}); end
        step(); idle_inputs();
        settle();
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL wr_release got=%b want=00", grant); end
        step();
    endtask

    task automatic test_timeout();
        step(); m0_valid = 1; m0_addr = 32'h20400100; s_rdata = 32'h00000055;
        for (int k = 1; k <= T; k++) begin
            step(); settle();
            total++; if ({s_valid, m0_ready} !== 2'b10) begin bad++; $display("FAIL to_wait%0d got=%b want=10", k, {s_valid, m0_ready}); end
        end
        step(); settle();
        total++; if ({m0_ready, m0_err, s_valid} !== 3'b110) begin
            bad++; $display("FAIL to_fire got=%b want=110", {m0_ready, m0_err, s_valid});
        end
        total++; if (m0_rdata !== ERR) begin bad++; $display("FAIL to_rdata got=%h want=%h", m0_rdata, ERR); end
        total++; if ({m1_ready, m1_err, m1_rdata} !== {2'b00, 32'h00000055}) begin
            bad++; $display("FAIL to_other got=%b%b/%h want=00/00000055", m1_ready, m1_err, m1_rdata);
        end
        step(); m0_valid = 0;
        settle();
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL to_release got=%b want=00", grant); end
        step(); m0_valid = 1; m1_valid = 1;
        step(); s_ready = 1;
        settle();
        total++; if ({grant, m1_ready, m1_err} !== 4'b1010) begin
            bad++; $display("FAIL to_next_m1 got=%b want=1010", {grant, m1_ready, m1_err});
        end
        step(); idle_inputs();
        step();
    endtask

    task automatic test_abort();
        step(); m0_valid = 1;
        step(); s_ready = 1;
        settle();
        total++; if (m0_ready !== 1'b1) begin bad++; $display("FAIL ab_pre got=%b want=1", m0_ready); end
        step(); m0_valid = 0; s_ready = 0;
        step(); m1_valid = 1;
        step(); settle();
        total++; if ({grant, s_valid} !== 3'b101) begin bad++; $display("FAIL ab_busy got=%b want=101", {grant, s_valid}); end
        step();
        step(); m1_valid = 0;
        settle();
        total++; if ({s_valid, m1_ready, m1_err, m0_ready} !== 4'b0) begin
            bad++; $display("FAIL ab_drop got=%b want=0000", {s_valid, m1_ready, m1_err, m0_ready});
        end
        step(); settle();
        total++; if ({grant, s_valid, m1_ready} !== 4'b0) begin bad++; $display("FAIL ab_release got=%b want=0000", {grant, s_valid, m1_ready}); end
        step(); m0_valid = 1; m1_valid = 1;
        step(); s_ready = 1;
        settle();
        total++; if ({grant, m1_ready} !== 3'b101) begin bad++; $display("FAIL ab_after got=%b want=101", {grant, m1_ready}); end
        step(); idle_inputs();
        step();
    endtask

    task automatic test_reset_midop();
        step(); m0_valid = 1;
        step();
        step(); reset = 1;
        settle();
        total++; if (s_valid !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b want=1", s_valid); end
        step(); reset = 0; m1_valid = 1;
        settle();
        total++; if ({s_valid, grant, m0_ready, m0_err} !== 5'b0) begin
            bad++; $display("FAIL rst_mid got=%b want=00000", {s_valid, grant, m0_ready, m0_err});
        end
        step(); s_ready = 1;
        settle();
        total++; if ({grant, m0_ready} !== 3'b011) begin bad++; $display("FAIL rst_after got=%b want=011", {grant, m0_ready}); end
        step(); idle_inputs();
        step();
    endtask

    task automatic test_random();
        int unsigned txn_start, free_at, k;
        bit          in_txn, hang, w, last_w, tmo;
        bit   [1:0]  done_m;
        logic [31:0] a[2], wd[2];
        logic [3:0]  we[2];
        bit          v[2];
        int          gap[2];
        logic [1:0]  gexp, rdy_exp, err_exp;
        logic        vexp;
        logic [31:0] rd_exp[2];
        do_reset();
        last_w = 1; in_txn = 0; hang = 0; w = 0; free_at = 0; txn_start = 0; done_m = 0;
        for (int m = 0; m < 2; m++) begin
            v[m] = 0; gap[m] = $urandom_range(0, 3); a[m] = 0; wd[m] = 0; we[m] = 0;
        end
        for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
            step();
            for (int m = 0; m < 2; m++) begin
                if (done_m[m]) begin
                    v[m] = 0; done_m[m] = 0; gap[m] = $urandom_range(0, 3);
                end else if (!v[m]) begin
                    if (gap[m] == 0) begin
                        v[m] = 1; a[m] = $urandom; wd[m] = $urandom; we[m] = 4'($urandom);
                    end else gap[m]--;
                end
            end
            m0_valid = v[0]; m0_addr = a[0]; m0_wdata = wd[0]; m0_wen = we[0];
            m1_valid = v[1]; m1_addr = a[1]; m1_wdata = wd[1]; m1_wen = we[1];
            s_rdata = $urandom;
            if (in_txn && cyc >= txn_start) s_ready = !hang && ($urandom_range(0, 2) == 0);
            else                            s_ready = ($urandom_range(0, 1) == 1);
            settle();
            gexp = 0; rdy_exp = 0; err_exp = 0; vexp = 0; tmo = 0;
            if (in_txn && cyc >= txn_start) begin
                k = cyc - txn_start;
                gexp = w ? 2'b10 : 2'b01;
                if (s_ready)     begin rdy_exp = gexp; vexp = 1; end
                else if (k == T) begin rdy_exp = gexp; err_exp = gexp; tmo = 1; end
                else vexp = 1;
                total++; if ({s_addr, s_wdata, s_wen} !== {a[w], wd[w], we[w]}) begin
                    bad++; $display("FAIL rnd_mux cyc=%0d got=%h/%h/%b want=%h/%h/%b", cyc, s_addr, s_wdata, s_wen, a[w], wd[w], we[w]);
                end
            end
            for (int m = 0; m < 2; m++) rd_exp[m] = (tmo && (m == int'(w))) ? ERR : s_rdata;
            total++; if (grant !== gexp) begin bad++; $display("FAIL rnd_grant cyc=%0d got=%b want=%b", cyc, grant, gexp); end
            total++; if (s_valid !== vexp) begin bad++; $display("FAIL rnd_s_valid cyc=%0d got=%b want=%b", cyc, s_valid, vexp); end
            total++; if ({m1_ready, m0_ready, m1_err, m0_err} !== {rdy_exp, err_exp}) begin
                bad++; $display("FAIL rnd_ready_err cyc=%0d got=%b want=%b", cyc, {m1_ready, m0_ready, m1_err, m0_err}, {rdy_exp, err_exp});
            end
            total++; if ({m0_rdata, m1_rdata} !== {rd_exp[0], rd_exp[1]}) begin
                bad++; $display("FAIL rnd_rdata cyc=%0d got=%h/%h want=%h/%h", cyc, m0_rdata, m1_rdata, rd_exp[0], rd_exp[1]);
            end
            if (rdy_exp != 2'b00) begin
                last_w = w; in_txn = 0; free_at = cyc + 2; done_m[w] = 1;
            end else if (!in_txn && cyc >= free_at && (v[0] || v[1])) begin
                w = (v[0] && v[1]) ? !last_w : v[1];
                in_txn = 1; txn_start = cyc + 1;
                hang = ($urandom_range(0, 5) == 0);
            end
        end
        step(); idle_inputs();
        step();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_write_mux();
        test_timeout();
        test_abort();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
